// File: rtl/branch_unit.sv
// Execute-stage branch resolution with a 2-bit-counter branch history table
// and saturating branch/mispredict statistics.
module branch_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BHT_IDX = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_branch,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             br_valid,
    output logic             br_taken,
    output logic             br_mispredict,
    output logic [XLEN-1:0]  br_redirect,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned BHT_N = 1 << BHT_IDX;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b010;
    localparam logic [2:0] OP_BGE  = 3'b011;
    localparam logic [2:0] OP_BLTU = 3'b100;
    localparam logic [2:0] OP_BGEU = 3'b101;

    logic [1:0]         bht_q [BHT_N];
    logic [1:0]         bht_d [BHT_N];
    logic               br_valid_q, br_valid_d;
    logic               br_taken_q, br_taken_d;
    logic               br_misp_q, br_misp_d;
    logic [XLEN-1:0]    br_redirect_q, br_redirect_d;
    logic [CNT_W-1:0]   stat_br_q, stat_br_d;
    logic [CNT_W-1:0]   stat_misp_q, stat_misp_d;

    logic               op_ok;
    logic               cond;
    logic               accept;
    logic               misp;
    logic [BHT_IDX-1:0] ex_idx;
    logic [BHT_IDX-1:0] f_idx;
    logic [1:0]         cnt_cur;
    logic [XLEN-1:0]    redirect;
    logic               unused_fpc;

    assign f_idx        = f_pc[BHT_IDX+1:2];
    assign ex_idx       = ex_pc[BHT_IDX+1:2];
    assign f_pred_taken = bht_q[f_idx][1];
    assign unused_fpc   = ^{f_pc[XLEN-1:BHT_IDX+2], f_pc[1:0]};

    // Branch condition decode; reserved and no-branch codes are not accepted
    always_comb begin
        op_ok = 1'b1;
        cond  = 1'b0;
        case (ex_branch)
            OP_BEQ:  cond = (ex_rs1 == ex_rs2);
            OP_BNE:  cond = (ex_rs1 != ex_rs2);
            OP_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            OP_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            OP_BLTU: cond = (ex_rs1 <  ex_rs2);
            OP_BGEU: cond = (ex_rs1 >= ex_rs2);
            default: op_ok = 1'b0;
        endcase
    end

    assign accept   = ex_valid & op_ok;
    assign misp     = cond ^ ex_pred_taken;
    assign redirect = ex_pc + (cond ? ex_imm : XLEN'(4));
    assign cnt_cur  = bht_q[ex_idx];

    // Next-state for results, statistics and the predictor table
    always_comb begin
        bht_d         = bht_q;
        br_valid_d    = accept;
        br_taken_d    = accept & cond;
        br_misp_d     = accept & misp;
        br_redirect_d = br_redirect_q;
        stat_br_d     = stat_br_q;
        stat_misp_d   = stat_misp_q;
        if (accept) begin
            br_redirect_d = redirect;
            if (stat_br_q != {CNT_W{1'b1}}) begin
                stat_br_d = stat_br_q + CNT_W'(1);
            end
            if (misp && (stat_misp_q != {CNT_W{1'b1}})) begin
                stat_misp_d = stat_misp_q + CNT_W'(1);
            end
            if (cond && (cnt_cur != 2'b11)) begin
                bht_d[ex_idx] = cnt_cur + 2'd1;
            end else if (!cond && (cnt_cur != 2'b00)) begin
                bht_d[ex_idx] = cnt_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_N); i++) begin
                bht_q[i] <= 2'b01;
            end
            br_valid_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            br_misp_q     <= 1'b0;
            br_redirect_q <= '0;
            stat_br_q     <= '0;
            stat_misp_q   <= '0;
        end else begin
            bht_q         <= bht_d;
            br_valid_q    <= br_valid_d;
            br_taken_q    <= br_taken_d;
            br_misp_q     <= br_misp_d;
            br_redirect_q <= br_redirect_d;
            stat_br_q     <= stat_br_d;
            stat_misp_q   <= stat_misp_d;
        end
    end

    assign br_valid         = br_valid_q;
    assign br_taken         = br_taken_q;
    assign br_mispredict    = br_misp_q;
    assign br_redirect      = br_redirect_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_misp_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed branches push expected results,
// a negedge monitor pops and compares whenever br_valid is seen.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] f_pc = '0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_branch = 3'b111;
    logic [31:0] ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0, ex_imm = '0;
    logic        ex_pred_taken = 1'b0;

    logic        f_pred_taken, br_valid, br_taken, br_mispredict;
    logic [31:0] br_redirect;
    logic [15:0] stat_branches, stat_mispredicts;

    logic        s_pred, s_valid, s_taken, s_misp;
    logic [31:0] s_redirect;
    logic [1:0]  s_branches, s_mispredicts;

    branch_unit dut (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .br_valid(br_valid), .br_taken(br_taken), .br_mispredict(br_mispredict),
        .br_redirect(br_redirect), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    branch_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(s_pred),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .br_valid(s_valid), .br_taken(s_taken), .br_mispredict(s_misp),
        .br_redirect(s_redirect), .stat_branches(s_branches),
        .stat_mispredicts(s_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic        misp;
        logic [31:0] redirect;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every result must match the oldest expectation, exactly one cycle late
    always @(negedge clk) begin
        if (br_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got br_valid=1 expected no result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                chk("br_taken", 32'(br_taken), 32'(e.taken));
                chk("br_mispredict", 32'(br_mispredict), 32'(e.misp));
                chk("br_redirect", br_redirect, e.redirect);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            void'(sb.pop_front());
            n_total++;
            $display("FAIL missing_result: got br_valid=%b expected 1 (t=%0t)", br_valid, $time);
        end
    end

    task automatic present(input logic v, input logic [2:0] br, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pred);
        ex_valid = v; ex_branch = br; ex_rs1 = rs1; ex_rs2 = rs2;
        ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
    endtask

    task automatic expect_res(input logic t, input logic pred, input logic [31:0] red);
        exp_t e;
        e.taken = t; e.misp = (t != pred); e.redirect = red; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] br, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                         input logic exp_t_taken, input logic [31:0] exp_red);
        @(negedge clk);
        present(1'b1, br, rs1, rs2, pc, imm, pred);
        expect_res(exp_t_taken, pred, exp_red);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        present(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_f_pred", 32'(f_pred_taken), 32'h0);
        chk("rst_br_valid", 32'(br_valid), 32'h0);
        chk("rst_br_taken", 32'(br_taken), 32'h0);
        chk("rst_br_misp", 32'(br_mispredict), 32'h0);
        chk("rst_redirect", br_redirect, 32'h0);
        chk("rst_stat_br", 32'(stat_branches), 32'h0);
        chk("rst_stat_misp", 32'(stat_mispredicts), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed vs unsigned compare on the same operands
        issue(3'b010, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120);
        after_edge();
        chk("blt_stat_misp", 32'(stat_mispredicts), 32'h1);
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h104);
        idle();
        f_pc = 32'h40;
        #1;
        chk("stat_br_2", 32'(stat_branches), 32'h2);
        chk("stat_misp_1", 32'(stat_mispredicts), 32'h1);
        chk("pred_idx0_01", 32'(f_pred_taken), 32'h0);

        // Counter training at index 0: 01->10->11->11->10->01
        issue(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1'b0, 1'b1, 32'h50);
        after_edge();
        chk("pred_after_10", 32'(f_pred_taken), 32'h1);
        issue(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1'b1, 1'b1, 32'h50);
        after_edge();
        chk("pred_after_11", 32'(f_pred_taken), 32'h1);
        issue(3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1'b1, 1'b1, 32'h50);
        after_edge();
        chk("pred_sat_11", 32'(f_pred_taken), 32'h1);
        issue(3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1'b1, 1'b0, 32'h44);
        after_edge();
        chk("pred_dec_10", 32'(f_pred_taken), 32'h1);
        issue(3'b001, 32'h5, 32'h5, 32'h40, 32'h10, 1'b1, 1'b0, 32'h44);
        after_edge();
        chk("pred_dec_01", 32'(f_pred_taken), 32'h0);
        chk("stat_br_7", 32'(stat_branches), 32'h7);
        chk("stat_misp_4", 32'(stat_mispredicts), 32'h4);

        // Redirect wrap-around and remaining compare types
        issue(3'b000, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b1, 32'h4);
        issue(3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 32'h0);
        issue(3'b011, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h204);
        issue(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h1FC);
        issue(3'b001, 32'h3, 32'h4, 32'h300, 32'h40, 1'b1, 1'b1, 32'h340);
        issue(3'b010, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b0, 1'b0, 32'h304);
        issue(3'b101, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b0, 1'b0, 32'h304);
        after_edge();
        chk("stat_br_14", 32'(stat_branches), 32'd14);
        chk("stat_misp_6", 32'(stat_mispredicts), 32'd6);

        // Ignored codes and ex_valid=0: no result, no stats, no BHT change
        @(negedge clk);
        present(1'b1, 3'b111, 32'h5, 32'h5, 32'h40, 32'h10, 1'b0);
        after_edge();
        chk("ign111_valid", 32'(br_valid), 32'h0);
        @(negedge clk);
        present(1'b1, 3'b110, 32'h5, 32'h5, 32'h40, 32'h10, 1'b0);
        after_edge();
        chk("ign110_valid", 32'(br_valid), 32'h0);
        @(negedge clk);
        present(1'b0, 3'b000, 32'h5, 32'h5, 32'h40, 32'h10, 1'b0);
        after_edge();
        chk("ign_nv_valid", 32'(br_valid), 32'h0);
        chk("ign_redirect_hold", br_redirect, 32'h304);
        chk("ign_stat_br", 32'(stat_branches), 32'd14);
        chk("ign_stat_misp", 32'(stat_mispredicts), 32'd6);
        chk("ign_bht", 32'(f_pred_taken), 32'h0);
        chk("small_stat_br_sat", 32'(s_branches), 32'h3);
        chk("small_stat_misp_sat", 32'(s_mispredicts), 32'h3);

        // Reset between branches
        issue(3'b000, 32'h9, 32'h9, 32'h40, 32'h10, 1'b0, 1'b1, 32'h50);
        issue(3'b000, 32'h9, 32'h9, 32'h40, 32'h10, 1'b1, 1'b1, 32'h50);
        after_edge();
        chk("pre_rst_pred", 32'(f_pred_taken), 32'h1);
        @(negedge clk);
        present(1'b1, 3'b000, 32'h9, 32'h9, 32'h40, 32'h10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(br_valid), 32'h0);
        chk("mid_rst_taken", 32'(br_taken), 32'h0);
        chk("mid_rst_redirect", br_redirect, 32'h0);
        chk("mid_rst_stat_br", 32'(stat_branches), 32'h0);
        chk("mid_rst_stat_misp", 32'(stat_mispredicts), 32'h0);
        chk("mid_rst_pred", 32'(f_pred_taken), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_res(1'b1, 1'b0, 32'h50);
        after_edge();
        chk("post_rst_stat_br", 32'(stat_branches), 32'h1);
        chk("post_rst_stat_misp", 32'(stat_mispredicts), 32'h1);
        chk("post_rst_pred", 32'(f_pred_taken), 32'h1);
        chk("post_rst_small_br", 32'(s_branches), 32'h1);
        idle();
        idle();
        idle();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
